// File: rtl/lfsr_pkg.sv
// lfsr_pkg
//   Shared definitions for the seedable Galois LFSR stream.
//   - get_mask(width)        : maximal-length Galois feedback mask, widths 4..64
//                              (returns 0 for unsupported widths)
//   - galois_step(state,mask): one right-shifting Galois step on a 64-bit container
//   - lfsr_state_e           : stream FSM states
package lfsr_pkg;

  localparam int unsigned MinLfsrWidth = 4;
  localparam int unsigned MaxLfsrWidth = 64;

  // Stream control states: waiting for a seed, producing the first word, streaming
  typedef enum logic [1:0] {
    StSeed = 2'd0,
    StFill = 2'd1,
    StRun  = 2'd2
  } lfsr_state_e;

  // Tap set for each width, expressed as a right-shift Galois mask:
  // tap t sets bit t-1, so width 8 with taps 8,6,5,4 gives 8'hB8.
  function automatic logic [63:0] get_mask(input int unsigned width);
    logic [63:0] mask;
    mask = 64'h0;
    case (width)
      4:  mask = 64'h0000_0000_0000_000C;
      5:  mask = 64'h0000_0000_0000_0014;
      6:  mask = 64'h0000_0000_0000_0030;
      7:  mask = 64'h0000_0000_0000_0060;
      8:  mask = 64'h0000_0000_0000_00B8;
      9:  mask = 64'h0000_0000_0000_0110;
      10: mask = 64'h0000_0000_0000_0240;
      11: mask = 64'h0000_0000_0000_0500;
      12: mask = 64'h0000_0000_0000_0829;
      13: mask = 64'h0000_0000_0000_100D;
      14: mask = 64'h0000_0000_0000_2015;
      15: mask = 64'h0000_0000_0000_6000;
      16: mask = 64'h0000_0000_0000_D008;
      17: mask = 64'h0000_0000_0001_2000;
      18: mask = 64'h0000_0000_0002_0400;
      19: mask = 64'h0000_0000_0004_0023;
      20: mask = 64'h0000_0000_0009_0000;
      21: mask = 64'h0000_0000_0014_0000;
      22: mask = 64'h0000_0000_0030_0000;
      23: mask = 64'h0000_0000_0042_0000;
      24: mask = 64'h0000_0000_00E1_0000;
      25: mask = 64'h0000_0000_0120_0000;
      26: mask = 64'h0000_0000_0200_0023;
      27: mask = 64'h0000_0000_0400_0013;
      28: mask = 64'h0000_0000_0900_0000;
      29: mask = 64'h0000_0000_1400_0000;
      30: mask = 64'h0000_0000_2000_0029;
      31: mask = 64'h0000_0000_4800_0000;
      32: mask = 64'h0000_0000_8020_0003;
      33: mask = 64'h0000_0001_0008_0000;
      34: mask = 64'h0000_0002_0400_0003;
      35: mask = 64'h0000_0005_0000_0000;
      36: mask = 64'h0000_0008_0100_0000;
      37: mask = 64'h0000_0010_0000_001F;
      38: mask = 64'h0000_0020_0000_0031;
      39: mask = 64'h0000_0044_0000_0000;
      40: mask = 64'h0000_00A0_0014_0000;
      41: mask = 64'h0000_0120_0000_0000;
      42: mask = 64'h0000_0300_000C_0000;
      43: mask = 64'h0000_0630_0000_0000;
      44: mask = 64'h0000_0C00_0003_0000;
      45: mask = 64'h0000_1B00_0000_0000;
      46: mask = 64'h0000_3000_0300_0000;
      47: mask = 64'h0000_4200_0000_0000;
      48: mask = 64'h0000_C000_0018_0000;
      49: mask = 64'h0001_0080_0000_0000;
      50: mask = 64'h0003_0000_00C0_0000;
      51: mask = 64'h0006_000C_0000_0000;
      52: mask = 64'h0009_0000_0000_0000;
      53: mask = 64'h0018_0030_0000_0000;
      54: mask = 64'h0030_0000_0003_0000;
      55: mask = 64'h0040_0000_4000_0000;
      56: mask = 64'h00C0_0006_0000_0000;
      57: mask = 64'h0102_0000_0000_0000;
      58: mask = 64'h0200_0040_0000_0000;
      59: mask = 64'h0600_0030_0000_0000;
      60: mask = 64'h0C00_0000_0000_0000;
      61: mask = 64'h1800_3000_0000_0000;
      62: mask = 64'h3000_0000_0000_0030;
      63: mask = 64'h6000_0000_0000_0000;
      64: mask = 64'hD800_0000_0000_0000;
      default: mask = 64'h0;
    endcase
    return mask;
  endfunction

  // The state must be zero above the LFSR width; the mask keeps it that way
  // because its top set bit is width-1.
  function automatic logic [63:0] galois_step(input logic [63:0] state,
                                              input logic [63:0] mask);
    return (state >> 1) ^ ({64{state[0]}} & mask);
  endfunction

endpackage

// File: rtl/lfsr_advance.sv
// lfsr_advance
//   Purely combinational: applies StepsPerOut Galois steps to the input state.
//   Ports:
//     state_i  in  LfsrWidth  current LFSR state
//     state_o  out LfsrWidth  state after StepsPerOut steps
module lfsr_advance import lfsr_pkg::*; #(
  parameter int unsigned LfsrWidth   = 32,
  parameter int unsigned StepsPerOut = 1
) (
  input  logic [LfsrWidth-1:0] state_i,
  output logic [LfsrWidth-1:0] state_o
);

  localparam logic [LfsrWidth-1:0] Mask = LfsrWidth'(get_mask(LfsrWidth));

  logic [LfsrWidth-1:0] chain [StepsPerOut+1];

  assign chain[0] = state_i;

  // The package step works on a 64-bit container; the truncation back to
  // LfsrWidth only drops bits that are always zero.
  for (genvar s = 0; s < StepsPerOut; s++) begin : g_step
    assign chain[s+1] = LfsrWidth'(galois_step(64'(chain[s]), 64'(Mask)));
  end

  assign state_o = chain[StepsPerOut];

endmodule

// File: rtl/lfsr_stream.sv
// lfsr_stream
//   Seedable Galois-LFSR random source with a valid/ready output stream.
//   Ports:
//     clk_i         in   clock
//     rst_ni        in   asynchronous active-low reset
//     seed_valid_i  in   seed offered (always accepted)
//     seed_ready_o  out  tied high
//     seed_i        in   seed value; zero is replaced by RstVal
//     out_valid_o   out  out_o holds a fresh word (registered)
//     out_ready_i   in   consumer takes the word
//     out_o         out  low OutWidth bits of the advanced state (registered)
//     cnt_o         out  draws completed since reset or last seed (wraps)
//     err_o         out  one-cycle pulse on zero-seed substitution or lockup recovery
module lfsr_stream import lfsr_pkg::*; #(
  parameter int unsigned LfsrWidth   = 32,
  parameter int unsigned OutWidth    = 8,
  parameter int unsigned StepsPerOut = 1,
  parameter logic [63:0] RstVal      = 64'd1,
  parameter bit          RequireSeed = 1'b0,
  parameter int unsigned CntWidth    = 32
) (
  input  logic                 clk_i,
  input  logic                 rst_ni,
  input  logic                 seed_valid_i,
  output logic                 seed_ready_o,
  input  logic [LfsrWidth-1:0] seed_i,
  output logic                 out_valid_o,
  input  logic                 out_ready_i,
  output logic [OutWidth-1:0]  out_o,
  output logic [CntWidth-1:0]  cnt_o,
  output logic                 err_o
);

  localparam logic [LfsrWidth-1:0] RstState   = RstVal[LfsrWidth-1:0];
  localparam lfsr_state_e          ResetState = RequireSeed ? StSeed : StFill;

  // Parameter legality is checked while elaborating
  if (LfsrWidth < MinLfsrWidth || LfsrWidth > MaxLfsrWidth) begin : g_bad_width
    $fatal(1, "lfsr_stream: LfsrWidth must be within 4..64");
  end
  if (OutWidth < 1 || OutWidth > LfsrWidth) begin : g_bad_out
    $fatal(1, "lfsr_stream: OutWidth must be within 1..LfsrWidth");
  end
  if (StepsPerOut < 1 || StepsPerOut > LfsrWidth) begin : g_bad_steps
    $fatal(1, "lfsr_stream: StepsPerOut must be within 1..LfsrWidth");
  end
  if (CntWidth < 1) begin : g_bad_cnt
    $fatal(1, "lfsr_stream: CntWidth must be at least 1");
  end
  if (RstState == '0) begin : g_bad_rst
    $fatal(1, "lfsr_stream: RstVal must be nonzero within LfsrWidth bits");
  end

  lfsr_state_e          state_q;
  logic [LfsrWidth-1:0] lfsr_q;
  logic [LfsrWidth-1:0] lfsr_d;
  logic [LfsrWidth-1:0] seed_d;
  logic [OutWidth-1:0]  out_q;
  logic                 out_valid_q;
  logic [CntWidth-1:0]  cnt_q;
  logic                 err_q;
  logic                 seed_zero;
  logic                 lockup;
  logic                 handshake;

  lfsr_advance #(
    .LfsrWidth  (LfsrWidth),
    .StepsPerOut(StepsPerOut)
  ) u_advance (
    .state_i(lfsr_q),
    .state_o(lfsr_d)
  );

  assign seed_zero = (seed_i == '0);
  assign seed_d    = seed_zero ? RstState : seed_i;
  // An all-zero state never leaves zero; it can only come from an upset or a force
  assign lockup    = (lfsr_q == '0);
  assign handshake = out_valid_q & out_ready_i;

  // Priority: an accepted seed beats lockup recovery, which beats normal streaming.
  // A handshake in the same cycle as a seed still completes with the word that
  // was on out_o; the seed then restarts the count from zero.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      state_q     <= ResetState;
      lfsr_q      <= RstState;
      out_q       <= '0;
      out_valid_q <= 1'b0;
      cnt_q       <= '0;
      err_q       <= 1'b0;
    end else begin
      err_q <= 1'b0;
      if (seed_valid_i) begin
        lfsr_q      <= seed_d;
        cnt_q       <= '0;
        state_q     <= StFill;
        out_valid_q <= 1'b0;
        err_q       <= seed_zero;
      end else if (lockup) begin
        lfsr_q      <= RstState;
        state_q     <= StFill;
        out_valid_q <= 1'b0;
        err_q       <= 1'b1;
      end else begin
        unique case (state_q)
          StSeed: begin
            state_q     <= StSeed;
            out_valid_q <= 1'b0;
          end
          StFill: begin
            lfsr_q      <= lfsr_d;
            out_q       <= lfsr_d[OutWidth-1:0];
            out_valid_q <= 1'b1;
            state_q     <= StRun;
          end
          StRun: begin
            if (handshake) begin
              lfsr_q <= lfsr_d;
              out_q  <= lfsr_d[OutWidth-1:0];
              cnt_q  <= cnt_q + CntWidth'(1);
            end
          end
          default: begin
            state_q     <= StFill;
            out_valid_q <= 1'b0;
          end
        endcase
      end
    end
  end

  assign seed_ready_o = 1'b1;
  assign out_valid_o  = out_valid_q;
  assign out_o        = out_q;
  assign cnt_o        = cnt_q;
  assign err_o        = err_q;

endmodule

// File: tb/tb_lfsr_stream.sv
// tb_lfsr_stream
//   Self-checking bench for lfsr_stream (8-bit state, mask 8'hB8, RstVal 1).
//   Three instances share clock and reset: the default configuration, a
//   four-steps-per-draw variant with a 2-bit counter, and a seed-required variant.
module tb_lfsr_stream;

  typedef struct {
    logic        seedValid;
    logic [7:0]  seed;
    logic        outReady;
    logic        expValid;
    logic [7:0]  expOut;
    logic [31:0] expCnt;
    logic        expErr;
  } vector_t;

  typedef struct {
    logic        valid;
    logic [7:0]  out;
    logic [31:0] cnt;
    logic        err;
  } expect_t;

  logic        clk = 1'b0;
  logic        rstN = 1'b0;

  logic        seedValid = 1'b0;
  logic [7:0]  seed = 8'h00;
  logic        outReady = 1'b0;
  logic        seedReady;
  logic        outValid;
  logic [7:0]  outWord;
  logic [31:0] cnt;
  logic        err;

  logic        s4SeedValid = 1'b0;
  logic [7:0]  s4Seed = 8'h00;
  logic        s4Ready = 1'b1;
  logic        s4SeedReady;
  logic        s4Valid;
  logic [7:0]  s4Out;
  logic [1:0]  s4Cnt;
  logic        s4Err;

  logic        rsSeedValid = 1'b0;
  logic [7:0]  rsSeed = 8'h00;
  logic        rsReady = 1'b1;
  logic        rsSeedReady;
  logic        rsValid;
  logic [7:0]  rsOut;
  logic [31:0] rsCnt;
  logic        rsErr;

  vector_t     vectors [20];
  expect_t     expQ [$];
  logic [7:0]  s4ExpOut [5];
  logic [1:0]  s4ExpCnt [5];
  int          vectorsApplied = 0;
  int          miscompares = 0;

  // Free-running 10-unit clock shared by all instances
  always #5 clk = ~clk;

  lfsr_stream #(
    .LfsrWidth(8), .OutWidth(8), .StepsPerOut(1), .RstVal(64'h01),
    .RequireSeed(1'b0), .CntWidth(32)
  ) dut (
    .clk_i(clk), .rst_ni(rstN), .seed_valid_i(seedValid), .seed_ready_o(seedReady),
    .seed_i(seed), .out_valid_o(outValid), .out_ready_i(outReady), .out_o(outWord),
    .cnt_o(cnt), .err_o(err)
  );

  lfsr_stream #(
    .LfsrWidth(8), .OutWidth(8), .StepsPerOut(4), .RstVal(64'h01),
    .RequireSeed(1'b0), .CntWidth(2)
  ) dutSteps4 (
    .clk_i(clk), .rst_ni(rstN), .seed_valid_i(s4SeedValid), .seed_ready_o(s4SeedReady),
    .seed_i(s4Seed), .out_valid_o(s4Valid), .out_ready_i(s4Ready), .out_o(s4Out),
    .cnt_o(s4Cnt), .err_o(s4Err)
  );

  lfsr_stream #(
    .LfsrWidth(8), .OutWidth(8), .StepsPerOut(1), .RstVal(64'h01),
    .RequireSeed(1'b1), .CntWidth(32)
  ) dutReqSeed (
    .clk_i(clk), .rst_ni(rstN), .seed_valid_i(rsSeedValid), .seed_ready_o(rsSeedReady),
    .seed_i(rsSeed), .out_valid_o(rsValid), .out_ready_i(rsReady), .out_o(rsOut),
    .cnt_o(rsCnt), .err_o(rsErr)
  );

  function automatic vector_t mkVec(input logic sv, input logic [7:0] sd, input logic rdy,
                                    input logic ev, input logic [7:0] eo,
                                    input logic [31:0] ec, input logic ee);
    vector_t v;
    v.seedValid = sv; v.seed = sd; v.outReady = rdy;
    v.expValid = ev; v.expOut = eo; v.expCnt = ec; v.expErr = ee;
    return v;
  endfunction

  task automatic compareVal(input string name, input logic [31:0] actual,
                            input logic [31:0] expected);
    vectorsApplied++;
    if (actual !== expected) begin
      miscompares++;
      $display("[TB] FAIL %s: got %0h, expected %0h", name, actual, expected);
    end
  endtask

  // Drive one cycle of stimulus (called just after a falling edge), queue the
  // expected result, then step past the next rising edge.
  task automatic applyStimulus(input vector_t v);
    expect_t e;
    seedValid = v.seedValid;
    seed      = v.seed;
    outReady  = v.outReady;
    e.valid = v.expValid; e.out = v.expOut; e.cnt = v.expCnt; e.err = v.expErr;
    expQ.push_back(e);
    @(posedge clk);
    #1;
  endtask

  // Pop the oldest expectation and compare against the registered outputs;
  // the word itself only matters while it is marked valid.
  task automatic checkOutput(input int idx);
    expect_t e;
    if (expQ.size() == 0) begin
      compareVal($sformatf("v%0d queue", idx), 32'(expQ.size()), 32'd1);
    end else begin
      e = expQ.pop_front();
      compareVal($sformatf("v%0d valid", idx), 32'(outValid), 32'(e.valid));
      compareVal($sformatf("v%0d cnt", idx), cnt, e.cnt);
      compareVal($sformatf("v%0d err", idx), 32'(err), 32'(e.err));
      if (e.valid) compareVal($sformatf("v%0d out", idx), 32'(outWord), 32'(e.out));
    end
  endtask

  // Main sequence: reset checks, the vector table, then hand-written corner cases
  initial begin
    vectors[0]  = mkVec(1'b0, 8'h00, 1'b1, 1'b1, 8'hB8, 32'd0, 1'b0);
    vectors[1]  = mkVec(1'b0, 8'h00, 1'b1, 1'b1, 8'h5C, 32'd1, 1'b0);
    vectors[2]  = mkVec(1'b0, 8'h00, 1'b1, 1'b1, 8'h2E, 32'd2, 1'b0);
    vectors[3]  = mkVec(1'b0, 8'h00, 1'b1, 1'b1, 8'h17, 32'd3, 1'b0);
    vectors[4]  = mkVec(1'b0, 8'h00, 1'b1, 1'b1, 8'hB3, 32'd4, 1'b0);
    vectors[5]  = mkVec(1'b1, 8'h01, 1'b0, 1'b0, 8'h00, 32'd0, 1'b0);
    vectors[6]  = mkVec(1'b0, 8'h00, 1'b0, 1'b1, 8'hB8, 32'd0, 1'b0);
    vectors[7]  = mkVec(1'b0, 8'h00, 1'b0, 1'b1, 8'hB8, 32'd0, 1'b0);
    vectors[8]  = mkVec(1'b0, 8'h00, 1'b0, 1'b1, 8'hB8, 32'd0, 1'b0);
    vectors[9]  = mkVec(1'b0, 8'h00, 1'b0, 1'b1, 8'hB8, 32'd0, 1'b0);
    vectors[10] = mkVec(1'b0, 8'h00, 1'b0, 1'b1, 8'hB8, 32'd0, 1'b0);
    vectors[11] = mkVec(1'b0, 8'h00, 1'b0, 1'b1, 8'hB8, 32'd0, 1'b0);
    vectors[12] = mkVec(1'b0, 8'h00, 1'b1, 1'b1, 8'h5C, 32'd1, 1'b0);
    vectors[13] = mkVec(1'b0, 8'h00, 1'b1, 1'b1, 8'h2E, 32'd2, 1'b0);
    vectors[14] = mkVec(1'b1, 8'h17, 1'b1, 1'b0, 8'h00, 32'd0, 1'b0);
    vectors[15] = mkVec(1'b0, 8'h00, 1'b1, 1'b1, 8'hB3, 32'd0, 1'b0);
    vectors[16] = mkVec(1'b0, 8'h00, 1'b1, 1'b1, 8'hE1, 32'd1, 1'b0);
    vectors[17] = mkVec(1'b1, 8'h00, 1'b0, 1'b0, 8'h00, 32'd0, 1'b1);
    vectors[18] = mkVec(1'b0, 8'h00, 1'b0, 1'b1, 8'hB8, 32'd0, 1'b0);
    vectors[19] = mkVec(1'b0, 8'h00, 1'b1, 1'b1, 8'h5C, 32'd1, 1'b0);

    s4ExpOut[0] = 8'h17; s4ExpOut[1] = 8'h64; s4ExpOut[2] = 8'h5A;
    s4ExpOut[3] = 8'h93; s4ExpOut[4] = 8'h30;
    s4ExpCnt[0] = 2'd0;  s4ExpCnt[1] = 2'd1;  s4ExpCnt[2] = 2'd2;
    s4ExpCnt[3] = 2'd3;  s4ExpCnt[4] = 2'd0;

    #7;
    compareVal("reset valid", 32'(outValid), 32'd0);
    compareVal("reset out", 32'(outWord), 32'd0);
    compareVal("reset cnt", cnt, 32'd0);
    compareVal("reset err", 32'(err), 32'd0);
    compareVal("seed ready", 32'(seedReady), 32'd1);
    compareVal("reqseed reset valid", 32'(rsValid), 32'd0);

    @(negedge clk);
    rstN = 1'b1;

    for (int i = 0; i < 20; i++) begin
      applyStimulus(vectors[i]);
      checkOutput(i);
      if (i < 5) begin
        compareVal($sformatf("steps4 w%0d out", i), 32'(s4Out), 32'(s4ExpOut[i]));
        compareVal($sformatf("steps4 w%0d cnt", i), 32'(s4Cnt), 32'(s4ExpCnt[i]));
        compareVal($sformatf("steps4 w%0d valid", i), 32'(s4Valid), 32'd1);
      end
      compareVal($sformatf("reqseed idle c%0d", i), 32'(rsValid), 32'd0);
      @(negedge clk);
    end
    compareVal("steps4 err", 32'(s4Err), 32'd0);

    // Lockup: hold the stream, zero the state for one edge, and seed the
    // seed-required instance on the same edge.
    seedValid   = 1'b0;
    outReady    = 1'b0;
    rsSeedValid = 1'b1;
    rsSeed      = 8'h2E;
    force dut.lfsr_q = 8'h00;
    @(posedge clk);
    #1;
    force dut.lfsr_q = 8'h01;
    release dut.lfsr_q;
    compareVal("lockup err", 32'(err), 32'd1);
    compareVal("lockup valid", 32'(outValid), 32'd0);
    compareVal("lockup cnt", cnt, 32'd1);
    compareVal("reqseed seeded valid", 32'(rsValid), 32'd0);

    @(negedge clk);
    rsSeedValid = 1'b0;
    @(posedge clk);
    #1;
    compareVal("recover err", 32'(err), 32'd0);
    compareVal("recover valid", 32'(outValid), 32'd1);
    compareVal("recover out", 32'(outWord), 32'hB8);
    compareVal("recover cnt", cnt, 32'd1);
    compareVal("reqseed first valid", 32'(rsValid), 32'd1);
    compareVal("reqseed first out", 32'(rsOut), 32'h17);
    compareVal("reqseed first cnt", rsCnt, 32'd0);
    compareVal("reqseed err", 32'(rsErr), 32'd0);

    @(negedge clk);
    outReady = 1'b1;
    @(posedge clk);
    #1;
    compareVal("post-recover out", 32'(outWord), 32'h5C);
    compareVal("post-recover cnt", cnt, 32'd2);

    // Asynchronous reset in the middle of a cycle
    #2;
    rstN = 1'b0;
    #1;
    compareVal("async reset valid", 32'(outValid), 32'd0);
    compareVal("async reset out", 32'(outWord), 32'd0);
    compareVal("async reset cnt", cnt, 32'd0);
    compareVal("async reset steps4 cnt", 32'(s4Cnt), 32'd0);
    compareVal("async reset reqseed valid", 32'(rsValid), 32'd0);

    $display("== %0d vectors applied, %0d miscompares ==", vectorsApplied, miscompares);
    $finish;
  end

endmodule
